// File: rtl/sync_fifo_w8_pkg.sv
// Shared defaults and helpers for the sync_fifo_w8 FWFT FIFO.
package sync_fifo_w8_pkg;

  localparam int unsigned FIFO_W8_DEFAULT_WIDTH = 16;
  localparam int unsigned FIFO_W8_DEFAULT_DEPTH = 8;
  localparam int unsigned FIFO_W8_DEFAULT_PFULL = 4;

  function automatic int unsigned fifo_w8_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_w8_ram.sv
// Register-array storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_w8_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_w8.sv
// Single-clock first-word-fall-through FIFO with programmable almost-full flag.
// Optional sticky overflow/underflow outputs are built when FIFO_W8_ERR_FLAGS_EN is defined.
module sync_fifo_w8
  import sync_fifo_w8_pkg::*;
#(
  parameter int unsigned WIDTH            = FIFO_W8_DEFAULT_WIDTH,
  parameter int unsigned DEPTH            = FIFO_W8_DEFAULT_DEPTH,
  parameter int unsigned PROG_FULL_THRESH = FIFO_W8_DEFAULT_PFULL
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_we,
  output logic [WIDTH-1:0] data_o,
  input  logic             data_rd,
  output logic             prog_full,
  output logic             full,
  output logic             empty
`ifdef FIFO_W8_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int unsigned PTR_W = fifo_w8_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PFULL_C = CNT_W'(PROG_FULL_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_acc, rd_acc;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign prog_full = (count_q >= PFULL_C);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  always_comb begin
    rd_acc   = data_rd & ~empty;
    wr_acc   = data_we & (~full | rd_acc);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_w8_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_acc & aresetn),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );

`ifdef FIFO_W8_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (data_we & full & ~data_rd) overflow_q <= 1'b1;
      if (data_rd & empty)           underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_w8.sv
// Self-checking bench for sync_fifo_w8: directed vector table, randomized stream against a queue model, reset flush.
module tb_sync_fifo_w8;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int PF    = 4;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] data_i;
  logic         data_we;
  logic [W-1:0] data_o;
  logic         data_rd;
  logic         prog_full, full, empty;
`ifdef FIFO_W8_ERR_FLAGS_EN
  logic         overflow, underflow;
`endif

  sync_fifo_w8 #(
    .WIDTH            (W),
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (PF)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .data_i    (data_i),
    .data_we   (data_we),
    .data_o    (data_o),
    .data_rd   (data_rd),
    .prog_full (prog_full),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_W8_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic         we;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;   // occupancy expected after the edge
    logic [W-1:0] dout;  // head expected after the edge (ignored when cnt==0)
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] model_q[$];

  function automatic void add(input logic we, input logic rd, input logic [W-1:0] din,
                              input int cnt, input logic [W-1:0] dout);
    vec_t v;
    v.we = we; v.rd = rd; v.din = din; v.cnt = cnt; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic rd, input logic [W-1:0] d);
    @(negedge aclk);
    data_we = we;
    data_rd = rd;
    data_i  = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [W-1:0] dout);
    chk({tag, " empty"},     32'(empty),     32'(cnt == 0));
    chk({tag, " full"},      32'(full),      32'(cnt == DEPTH));
    chk({tag, " prog_full"}, 32'(prog_full), 32'(cnt >= PF));
    if (cnt != 0) chk({tag, " data_o"}, 32'(data_o), 32'(dout));
  endtask

  initial begin
    logic [W-1:0] exp_head;
    int           nw;
    int           wprob, rprob;
    logic         we, rd, fl, em, wacc, racc;
    logic [W-1:0] d;

    aresetn = 1'b0; data_we = 1'b0; data_rd = 1'b0; data_i = '0;
    @(posedge aclk); @(posedge aclk); #1;
    chk_state("reset", 0, '0);
    aresetn = 1'b1;

    // Plan 1: idle, single word, pop
    add(0, 0, 16'h0000, 0, 16'h0000);
    add(1, 0, 16'h1234, 1, 16'h1234);
    add(0, 1, 16'h0000, 0, 16'h0000);
    // Plan 2: fill, dropped write, drain in order
    for (int k = 1; k <= 8; k++) add(1, 0, 16'(k), k, 16'h0001);
    add(1, 0, 16'hDEAD, 8, 16'h0001);
    for (int j = 1; j <= 8; j++) add(0, 1, 16'h0000, 8 - j, 16'(j + 1));
    // Plan 3: simultaneous write+pop while full
    for (int k = 1; k <= 8; k++) add(1, 0, 16'(k), k, 16'h0001);
    add(1, 1, 16'h00AA, 8, 16'h0002);
    for (int j = 1; j <= 8; j++) add(0, 1, 16'h0000, 8 - j, (j < 7) ? 16'(j + 2) : 16'h00AA);
    // Plan 4: write+pop while empty, then pop while empty
    add(1, 1, 16'h0055, 1, 16'h0055);
    add(0, 1, 16'h0000, 0, 16'h0000);
    add(0, 1, 16'h0000, 0, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].rd, vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout);
    end
`ifdef FIFO_W8_ERR_FLAGS_EN
    chk("overflow sticky",  32'(overflow),  32'd1);
    chk("underflow sticky", 32'(underflow), 32'd1);
`endif

    // Plan 5: randomized stream against a queue model
    nw = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (((cyc / 40) % 2) == 0) begin wprob = 80; rprob = 30; end
      else                       begin wprob = 30; rprob = 80; end
      we = (nw < 100) && ($urandom_range(0, 99) < wprob);
      rd = ($urandom_range(0, 99) < rprob);
      d  = 16'($urandom);
      em   = (model_q.size() == 0);
      fl   = (model_q.size() == DEPTH);
      racc = rd && !em;
      wacc = we && (!fl || racc);
      if (racc) void'(model_q.pop_front());
      if (wacc) begin model_q.push_back(d); nw++; end
      drive(we, rd, d);
      exp_head = (model_q.size() != 0) ? model_q[0] : '0;
      chk_state($sformatf("rand%0d", cyc), model_q.size(), exp_head);
    end
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) begin
      void'(model_q.pop_front());
      drive(0, 1, '0);
      exp_head = (model_q.size() != 0) ? model_q[0] : '0;
      chk_state($sformatf("drain%0d", i), model_q.size(), exp_head);
    end

    // Plan 6: reset with five words stored, write/pop ignored in the reset cycle
    for (int k = 0; k < 5; k++) drive(1, 0, 16'hA0 + 16'(k));
    chk_state("pre-reset", 5, 16'h00A0);
    @(negedge aclk);
    aresetn = 1'b0; data_we = 1'b1; data_rd = 1'b1; data_i = 16'h00EE;
    @(posedge aclk); #1;
    chk_state("mid-reset", 0, '0);
`ifdef FIFO_W8_ERR_FLAGS_EN
    chk("overflow cleared",  32'(overflow),  32'd0);
    chk("underflow cleared", 32'(underflow), 32'd0);
`endif
    @(negedge aclk);
    aresetn = 1'b1; data_we = 1'b0; data_rd = 1'b0;
    drive(0, 0, '0);
    chk_state("post-reset idle", 0, '0);
    drive(1, 0, 16'h0077);
    chk_state("post-reset wr", 1, 16'h0077);
    drive(1, 1, 16'h0078);
    chk_state("post-reset wr+rd", 1, 16'h0078);
    drive(0, 1, '0);
    chk_state("post-reset pop", 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
